if_fetch_queue: RTL and testbench
=================================

Name: if_fetch_queue

Overview:
- Parametrised successor to the single-entry fetch stage.
- Combines pre-IF PC generation with IF-stage instruction fetch.
- Keeps up to MAX_OUTST fetch requests in flight on the inst_sram SRAM-like request/addr_ok/data_ok bus.
- Buffers returned instructions in a FIFO_DEPTH-entry queue feeding ID.
- Redirects (exception/ertn flush, branch) squash the queue and discard stale in-flight responses by counting them.

Parameters:
- RESET_PC, 32'h1c000000, first fetch address after reset.
- FIFO_DEPTH, 4, instruction queue entries (power of two, ≥2).
- MAX_OUTST, 2, maximum requests accepted by addr_ok and not yet returned by data_ok (1..FIFO_DEPTH).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- flush  in  1  exception or ertn redirect from WB
- flush_target  in  32  ex_entry/er_entry already selected by CSR
- br_taken  in  1  branch redirect from ID
- br_target  in  32  branch target
- br_stall  in  1  ID cannot resolve branch yet; suppress new requests
- inst_sram_req  out  1  request valid
- inst_sram_wr  out  1  constant 0
- inst_sram_size  out  2  constant 2'b10
- inst_sram_wstrb  out  4  constant 0
- inst_sram_addr  out  32  fetch address
- inst_sram_wdata  out  32  constant 0
- inst_sram_addr_ok  in  1  request accepted
- inst_sram_data_ok  in  1  read data returned, in request order
- inst_sram_rdata  in  32  instruction word
- out_valid  out  1  queue head valid
- out_ready  in  1  ID allow_in
- out_pc  out  32  head PC
- out_inst  out  32  head instruction (0 when out_adef)
- out_adef  out  1  head carries ADEF exception

Behaviour:
- State registers: fetch_pc; outst_cnt (width $clog2(MAX_OUTST+1)); discard_cnt (same width); pc tag FIFO (MAX_OUTST entries); instruction FIFO ({adef, pc, inst}, FIFO_DEPTH entries); halted flag.
- Reset:
  - fetch_pc=RESET_PC; counters 0; both FIFOs empty; halted=0.
  - Outputs: out_valid=0, inst_sram_req=0, inst_sram_addr=RESET_PC; out_pc, out_inst, out_adef are don't-care while out_valid=0.
- redirect = flush | br_taken. flush has priority: target = flush ? flush_target : br_target.
- Request issue: inst_sram_req = !reset & !redirect & !br_stall & !halted & fetch_pc[1:0]==0 & outst_cnt<MAX_OUTST & (outst_cnt + inst_fifo_count) < FIFO_DEPTH (credit rule: every accepted request has a guaranteed queue slot).
- inst_sram_addr = fetch_pc.
- req & addr_ok: push fetch_pc to tag FIFO, outst_cnt++, fetch_pc += 4 (32-bit wrap).
- data_ok: pop tag FIFO, outst_cnt--.
  - If discard_cnt>0: discard_cnt--, drop data.
  - Else: push {0, tag, rdata} to instruction FIFO.
  - Data may return the same cycle as the address is accepted; in that case outst_cnt is unchanged.
- Same-cycle push and pop on the instruction FIFO are allowed, including when it is full.
- ADEF: when fetch_pc[1:0]!=0, !halted, !redirect, outst_cnt==0 and the FIFO has space, push {1, fetch_pc, 0} and set halted=1. No SRAM request is issued for a misaligned PC.
- Redirect cycle:
  - Instruction FIFO cleared; any out_ready pop that cycle is void.
  - fetch_pc = target; halted=0.
  - discard_cnt = outst_cnt - data_ok (the response returning this cycle is dropped).
  - Tag FIFO and outst_cnt still update normally for responses.
  - No request is issued in the redirect cycle; fetch resumes the next cycle.
- Output: out_valid = instruction FIFO non-empty; head fields come straight from the FIFO; pop on out_valid & out_ready.
- Reset mid-transaction: all state returns to reset values. The SRAM slave is reset by the same signal, so no discard is required.

Optional Feature:
- IF_PERF_CNT_EN defined:
  - Adds outputs perf_fetch_cnt[31:0] (instructions pushed to queue), perf_discard_cnt[31:0] (data_ok responses dropped) and perf_stall_cnt[31:0] (cycles with out_valid=0 and !reset).
  - All wrap at 2^32 and reset to 0.
- Undefined: these ports and registers do not exist; all other behaviour is identical.

Decomposition:
- Shared package my_cpu_pkg:
  - IF_TO_ID_W = 65 ({adef, pc, inst})
  - INST_SRAM_SIZE_WORD = 2'b10
  - ADEF ecode constant
- Sub-module: generic sync_fifo (WIDTH, DEPTH; push, pop, clear, full, empty, count), instantiated twice: tag FIFO and instruction FIFO.

Test Plan:
- Reset release, slave with addr_ok=1 and data_ok 1 cycle later, out_ready=1 → out_pc sequence 1c000000, 1c000004, 1c000008…; outst_cnt never exceeds 2.
- out_ready=0 for 10 cycles → exactly 4 instructions queued; inst_sram_req drops once outst_cnt + count = 4; no instruction lost when out_ready returns to 1.
- Two requests outstanding, flush with flush_target=1c008000 → both returned words dropped (discard_cnt 2→0); next out_pc = 1c008000.
- br_taken with br_target=1c000102 → out_valid with out_adef=1, out_pc=1c000102, out_inst=0; no SRAM request issued until a later flush to 1c008000.
- br_stall=1 for 3 cycles → inst_sram_req=0 throughout; data_ok in flight still enqueues.
- redirect in the same cycle as data_ok with outst_cnt=1 → discard_cnt=0; word dropped; first instruction after the redirect is from target.

Source files
------------

// File: rtl/my_cpu_pkg.sv
// Shared CPU definitions: IF->ID payload layout and instruction SRAM constants.
package my_cpu_pkg;

  localparam int unsigned IF_TO_ID_W          = 65;
  localparam logic [1:0]  INST_SRAM_SIZE_WORD = 2'b10;
  localparam logic [5:0]  ECODE_ADEF          = 6'h08;

  typedef struct packed {
    logic        adef;
    logic [31:0] pc;
    logic [31:0] inst;
  } if_to_id_t;

endpackage

// File: rtl/if_fetch_queue_sync_fifo.sv
// Generic synchronous FIFO with occupancy count and synchronous clear.
// Push while full is accepted only when a pop happens in the same cycle.
module sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       clear,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= bump(wr_ptr);
      if (do_pop)  rd_ptr <= bump(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/if_fetch_queue.sv
// Pre-IF/IF fetch stage with MAX_OUTST requests in flight and a FIFO_DEPTH instruction queue.
// Define IF_PERF_CNT_EN to add the perf_fetch_cnt/perf_discard_cnt/perf_stall_cnt outputs.
module if_fetch_queue
  import my_cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h1c000000,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned MAX_OUTST  = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic [31:0] flush_target,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        br_stall,
  output logic        inst_sram_req,
  output logic        inst_sram_wr,
  output logic [1:0]  inst_sram_size,
  output logic [3:0]  inst_sram_wstrb,
  output logic [31:0] inst_sram_addr,
  output logic [31:0] inst_sram_wdata,
  input  logic        inst_sram_addr_ok,
  input  logic        inst_sram_data_ok,
  input  logic [31:0] inst_sram_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst,
  output logic        out_adef
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_discard_cnt,
  output logic [31:0] perf_stall_cnt
`endif
);

  localparam int unsigned OW = $clog2(MAX_OUTST + 1);
  localparam int unsigned QW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned SW = $clog2(FIFO_DEPTH + MAX_OUTST + 1);

  logic [31:0] fetch_pc;
  logic [OW-1:0] outst_cnt;
  logic [OW-1:0] discard_cnt;
  logic        halted;

  logic        redirect;
  logic [31:0] target;
  logic        accept;
  logic        credit_ok;
  logic        resp_keep;
  logic        adef_push;

  logic        tag_push, tag_pop, tag_full, tag_empty;
  logic [31:0] tag_dout, resp_tag;

  if_to_id_t   inst_din, inst_dout;
  logic        inst_push, inst_pop, inst_full, inst_empty;
  logic [QW-1:0] inst_count;

  assign redirect = flush | br_taken;
  assign target   = flush ? flush_target : br_target;

  // outst_cnt is the tag FIFO occupancy; tag_full is outst_cnt == MAX_OUTST.
  assign credit_ok     = (SW'(outst_cnt) + SW'(inst_count)) < SW'(FIFO_DEPTH);
  assign inst_sram_req = ~reset & ~redirect & ~br_stall & ~halted &
                         (fetch_pc[1:0] == 2'b00) & ~tag_full & credit_ok;
  assign accept        = inst_sram_req & inst_sram_addr_ok;

  assign inst_sram_wr    = 1'b0;
  assign inst_sram_size  = INST_SRAM_SIZE_WORD;
  assign inst_sram_wstrb = '0;
  assign inst_sram_wdata = '0;
  assign inst_sram_addr  = fetch_pc;

  // A response in the acceptance cycle of an otherwise idle bus bypasses the tag FIFO.
  assign tag_push = accept & ~(inst_sram_data_ok & tag_empty);
  assign tag_pop  = inst_sram_data_ok & ~tag_empty;
  assign resp_tag = tag_empty ? fetch_pc : tag_dout;

  sync_fifo #(.WIDTH(32), .DEPTH(MAX_OUTST)) u_tag_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (tag_push),
    .pop   (tag_pop),
    .clear (1'b0),
    .din   (fetch_pc),
    .dout  (tag_dout),
    .full  (tag_full),
    .empty (tag_empty),
    .count (outst_cnt)
  );

  assign resp_keep = inst_sram_data_ok & ~redirect & (discard_cnt == '0);
  assign adef_push = (fetch_pc[1:0] != 2'b00) & ~halted & ~redirect &
                     (outst_cnt == '0) & ~inst_full;
  assign inst_push = resp_keep | adef_push;
  assign inst_pop  = out_valid & out_ready & ~redirect;

  always_comb begin
    inst_din = '0;
    if (resp_keep) begin
      inst_din.adef = 1'b0;
      inst_din.pc   = resp_tag;
      inst_din.inst = inst_sram_rdata;
    end else begin
      inst_din.adef = 1'b1;
      inst_din.pc   = fetch_pc;
      inst_din.inst = '0;
    end
  end

  sync_fifo #(.WIDTH(IF_TO_ID_W), .DEPTH(FIFO_DEPTH)) u_inst_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (inst_push),
    .pop   (inst_pop),
    .clear (redirect),
    .din   (inst_din),
    .dout  (inst_dout),
    .full  (inst_full),
    .empty (inst_empty),
    .count (inst_count)
  );

  assign out_valid = ~inst_empty;
  assign out_pc    = inst_dout.pc;
  assign out_inst  = inst_dout.inst;
  assign out_adef  = inst_dout.adef;

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      discard_cnt <= '0;
      halted      <= 1'b0;
    end else begin
      if (redirect) begin
        fetch_pc <= target;
        halted   <= 1'b0;
        // Everything still in flight is stale, except a response retiring right now.
        discard_cnt <= (inst_sram_data_ok && outst_cnt != '0) ? outst_cnt - OW'(1) : outst_cnt;
      end else begin
        if (accept)    fetch_pc <= fetch_pc + 32'd4;
        if (adef_push) halted   <= 1'b1;
        if (inst_sram_data_ok && discard_cnt != '0) discard_cnt <= discard_cnt - OW'(1);
      end
    end
  end

`ifdef IF_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetch_cnt   <= '0;
      perf_discard_cnt <= '0;
      perf_stall_cnt   <= '0;
    end else begin
      if (inst_push) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (inst_sram_data_ok && !resp_keep) perf_discard_cnt <= perf_discard_cnt + 32'd1;
      if (!out_valid) perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_fetch_queue.sv
// Self-checking bench for if_fetch_queue: SRAM slave model plus an in-order fetch-stream reference.
module tb_if_fetch_queue;

  localparam logic [31:0] RESET_PC   = 32'h1c000000;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned MAX_OUTST  = 2;

  logic        clk = 1'b0;
  logic        reset, flush, br_taken, br_stall;
  logic [31:0] flush_target, br_target;
  logic        inst_sram_req, inst_sram_wr;
  logic [1:0]  inst_sram_size;
  logic [3:0]  inst_sram_wstrb;
  logic [31:0] inst_sram_addr, inst_sram_wdata;
  logic        inst_sram_addr_ok, inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;
  logic        out_valid, out_ready, out_adef;
  logic [31:0] out_pc, out_inst;

  always #5 clk = ~clk;

  if_fetch_queue #(.RESET_PC(RESET_PC), .FIFO_DEPTH(FIFO_DEPTH), .MAX_OUTST(MAX_OUTST)) dut (
    .clk(clk), .reset(reset), .flush(flush), .flush_target(flush_target),
    .br_taken(br_taken), .br_target(br_target), .br_stall(br_stall),
    .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr), .inst_sram_size(inst_sram_size),
    .inst_sram_wstrb(inst_sram_wstrb), .inst_sram_addr(inst_sram_addr),
    .inst_sram_wdata(inst_sram_wdata), .inst_sram_addr_ok(inst_sram_addr_ok),
    .inst_sram_data_ok(inst_sram_data_ok), .inst_sram_rdata(inst_sram_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_inst(out_inst), .out_adef(out_adef)
  );

  int          tests = 0;
  int          fails = 0;
  int unsigned cyc = 0;
  int          aok_mode;
  int unsigned lat_min, lat_max;
  logic [31:0] acc_addr [$];
  int unsigned acc_due [$];
  int          acc_total, req_cnt, blocked_req, max_outst;
  logic        popped, dok_last, p_adef;
  logic [31:0] p_pc, p_inst;

  // Memory image seen by the slave: a distinct word per address.
  function automatic logic [31:0] word(input logic [31:0] pc);
    return {pc[15:0] ^ 16'h3c5a, pc[31:16] ^ pc[15:0]};
  endfunction

  // One clock of the SRAM slave and ID consumer; starts and ends at a falling edge.
  task automatic cycle();
    int unsigned l;
    logic req_s, acc, same;
    logic [31:0] addr_s;
    case (aok_mode)
      0:       inst_sram_addr_ok = 1'b0;
      1:       inst_sram_addr_ok = 1'b1;
      default: inst_sram_addr_ok = ($urandom_range(99) < 75);
    endcase
    #1;
    req_s  = inst_sram_req;
    addr_s = inst_sram_addr;
    if (req_s) req_cnt++;
    if (req_s && (flush || br_taken || br_stall || reset)) blocked_req++;
    acc  = req_s && inst_sram_addr_ok;
    l    = $urandom_range(lat_max, lat_min);
    same = 1'b0;
    inst_sram_data_ok = 1'b0;
    inst_sram_rdata   = $urandom;
    if (!reset) begin
      if (acc_addr.size() != 0 && acc_due[0] <= cyc) begin
        inst_sram_data_ok = 1'b1;
        inst_sram_rdata   = word(acc_addr[0]);
      end else if (acc_addr.size() == 0 && acc && l == 0) begin
        inst_sram_data_ok = 1'b1;
        inst_sram_rdata   = word(addr_s);
        same = 1'b1;
      end
    end
    #1;
    popped = out_valid && out_ready && !flush && !br_taken && !reset;
    p_pc   = out_pc;
    p_inst = out_inst;
    p_adef = out_adef;
    dok_last = inst_sram_data_ok;
    if (inst_sram_data_ok && !same) begin
      void'(acc_addr.pop_front());
      void'(acc_due.pop_front());
    end
    if (acc) acc_total++;
    if (acc && !same) begin
      acc_addr.push_back(addr_s);
      acc_due.push_back(cyc + l);
    end
    if (acc_addr.size() > max_outst) max_outst = acc_addr.size();
    @(posedge clk);
    cyc++;
    if (reset) begin
      acc_addr.delete();
      acc_due.delete();
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1; flush = 1'b0; br_taken = 1'b0; br_stall = 1'b0;
    repeat (2) cycle();
    reset = 1'b0;
    acc_total = 0; req_cnt = 0; max_outst = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1; out_ready = 1'b1; aok_mode = 1; lat_min = 1; lat_max = 1;
    repeat (3) cycle();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    tests++; if (inst_sram_req !== 1'b0) begin fails++; $display("FAIL reset_req: got %b want 0", inst_sram_req); end
    tests++; if (inst_sram_addr !== RESET_PC) begin fails++; $display("FAIL reset_addr: got %h want %h", inst_sram_addr, RESET_PC); end
    tests++;
    if (inst_sram_wr !== 1'b0 || inst_sram_size !== 2'b10 || inst_sram_wstrb !== 4'h0 || inst_sram_wdata !== 32'h0) begin
      fails++;
      $display("FAIL const_outputs: got wr=%b size=%b wstrb=%h wdata=%h want 0/10/0/0",
               inst_sram_wr, inst_sram_size, inst_sram_wstrb, inst_sram_wdata);
    end
  endtask

  task automatic test_stream();
    int n = 0;
    logic [31:0] exp = RESET_PC;
    out_ready = 1'b1; aok_mode = 1; lat_min = 1; lat_max = 1;
    do_reset();
    for (int i = 0; i < 40; i++) begin
      cycle();
      if (popped) begin
        tests++;
        if (p_pc !== exp || p_inst !== word(exp) || p_adef !== 1'b0) begin
          fails++;
          $display("FAIL stream_pop%0d: got pc=%h inst=%h adef=%b want pc=%h inst=%h adef=0", n, p_pc, p_inst, p_adef, exp, word(exp));
        end
        exp += 32'd4; n++;
      end
    end
    tests++; if (n < 16) begin fails++; $display("FAIL stream_count: got %0d pops want >=16", n); end
    tests++; if (max_outst > MAX_OUTST) begin fails++; $display("FAIL stream_outst: got %0d want <=%0d", max_outst, MAX_OUTST); end
  endtask

  task automatic test_backpressure();
    int n = 0;
    logic [31:0] exp = RESET_PC;
    out_ready = 1'b0; aok_mode = 1; lat_min = 1; lat_max = 1;
    do_reset();
    repeat (10) cycle();
    tests++; if (acc_total != FIFO_DEPTH) begin fails++; $display("FAIL bp_accepted: got %0d want %0d", acc_total, FIFO_DEPTH); end
    tests++; if (inst_sram_req !== 1'b0) begin fails++; $display("FAIL bp_req_drop: got %b want 0", inst_sram_req); end
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL bp_out_valid: got %b want 1", out_valid); end
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (popped) begin
        tests++;
        if (p_pc !== exp || p_inst !== word(exp)) begin
          fails++;
          $display("FAIL bp_pop%0d: got pc=%h inst=%h want pc=%h inst=%h", n, p_pc, p_inst, exp, word(exp));
        end
        exp += 32'd4; n++;
      end
    end
    tests++; if (n < 8) begin fails++; $display("FAIL bp_drain: got %0d pops want >=8", n); end
  endtask

  task automatic test_flush();
    int n = 0;
    logic [31:0] exp = 32'h1c008000;
    out_ready = 1'b0; aok_mode = 1; lat_min = 4; lat_max = 4;
    do_reset();
    repeat (2) cycle();
    tests++; if (acc_addr.size() != 2) begin fails++; $display("FAIL flush_setup: got %0d outstanding want 2", acc_addr.size()); end
    flush = 1'b1; flush_target = 32'h1c008000; br_target = 32'h1c00f000;
    cycle();
    flush = 1'b0; out_ready = 1'b1; lat_min = 1; lat_max = 1;
    for (int i = 0; i < 30 && n < 3; i++) begin
      cycle();
      if (popped) begin
        tests++;
        if (p_pc !== exp || p_inst !== word(exp) || p_adef !== 1'b0) begin
          fails++;
          $display("FAIL flush_pop%0d: got pc=%h inst=%h adef=%b want pc=%h inst=%h adef=0", n, p_pc, p_inst, p_adef, exp, word(exp));
        end
        exp += 32'd4; n++;
      end
    end
    tests++; if (n != 3) begin fails++; $display("FAIL flush_timeout: got %0d pops want 3", n); end
  endtask

  task automatic test_adef();
    int n = 0;
    logic [31:0] f_pc = '0, f_inst = '1;
    logic f_adef = 1'b0;
    out_ready = 1'b1; aok_mode = 1; lat_min = 1; lat_max = 1;
    do_reset();
    repeat (3) cycle();
    br_taken = 1'b1; br_target = 32'h1c000102;
    cycle();
    br_taken = 1'b0; req_cnt = 0;
    for (int i = 0; i < 15; i++) begin
      cycle();
      if (popped) begin
        if (n == 0) begin f_pc = p_pc; f_inst = p_inst; f_adef = p_adef; end
        n++;
      end
    end
    tests++; if (n != 1) begin fails++; $display("FAIL adef_count: got %0d pops want 1", n); end
    tests++;
    if (f_adef !== 1'b1 || f_pc !== 32'h1c000102 || f_inst !== 32'h0) begin
      fails++;
      $display("FAIL adef_entry: got adef=%b pc=%h inst=%h want 1/1c000102/0", f_adef, f_pc, f_inst);
    end
    tests++; if (req_cnt != 0) begin fails++; $display("FAIL adef_no_req: got %0d requests want 0", req_cnt); end
    flush = 1'b1; flush_target = 32'h1c008000;
    cycle();
    flush = 1'b0; n = 0;
    for (int i = 0; i < 20 && n == 0; i++) begin
      cycle();
      if (popped) begin
        n++;
        tests++;
        if (p_pc !== 32'h1c008000 || p_adef !== 1'b0 || p_inst !== word(32'h1c008000)) begin
          fails++;
          $display("FAIL adef_recover: got pc=%h adef=%b inst=%h want pc=1c008000 adef=0 inst=%h", p_pc, p_adef, p_inst, word(32'h1c008000));
        end
      end
    end
    tests++; if (n == 0) begin fails++; $display("FAIL adef_recover_timeout: got 0 pops want 1"); end
  endtask

  task automatic test_br_stall();
    int n = 0, r0;
    logic [31:0] exp = RESET_PC;
    out_ready = 1'b1; aok_mode = 1; lat_min = 2; lat_max = 2;
    do_reset();
    repeat (2) cycle();
    br_stall = 1'b1; r0 = req_cnt;
    repeat (3) begin
      cycle();
      if (popped) begin
        tests++;
        if (p_pc !== exp || p_inst !== word(exp)) begin
          fails++;
          $display("FAIL stall_pop%0d: got pc=%h inst=%h want pc=%h inst=%h", n, p_pc, p_inst, exp, word(exp));
        end
        exp += 32'd4; n++;
      end
    end
    br_stall = 1'b0;
    tests++; if (req_cnt != r0) begin fails++; $display("FAIL stall_req: got %0d requests want 0", req_cnt - r0); end
    tests++; if (n != 2) begin fails++; $display("FAIL stall_inflight: got %0d pops want 2", n); end
    for (int i = 0; i < 12; i++) begin
      cycle();
      if (popped) begin
        tests++;
        if (p_pc !== exp) begin fails++; $display("FAIL stall_resume: got pc=%h want %h", p_pc, exp); end
        exp += 32'd4; n++;
      end
    end
    tests++; if (n < 6) begin fails++; $display("FAIL stall_resume_count: got %0d pops want >=6", n); end
  endtask

  task automatic test_redirect_dataok();
    int n = 0;
    out_ready = 1'b1; aok_mode = 1; lat_min = 2; lat_max = 2;
    do_reset();
    cycle();
    aok_mode = 0;
    cycle();
    tests++;
    if (acc_addr.size() != 1 || acc_due[0] > cyc) begin
      fails++; $display("FAIL rdok_setup: got %0d outstanding want 1 due now", acc_addr.size());
    end
    br_taken = 1'b1; br_target = 32'h1c000200; flush_target = 32'h1c00f000;
    cycle();
    br_taken = 1'b0;
    tests++; if (dok_last !== 1'b1) begin fails++; $display("FAIL rdok_coincide: got data_ok=%b want 1", dok_last); end
    aok_mode = 1; lat_min = 1; lat_max = 1;
    for (int i = 0; i < 20 && n == 0; i++) begin
      cycle();
      if (popped) begin
        n++;
        tests++;
        if (p_pc !== 32'h1c000200 || p_inst !== word(32'h1c000200)) begin
          fails++;
          $display("FAIL rdok_first: got pc=%h inst=%h want pc=1c000200 inst=%h", p_pc, p_inst, word(32'h1c000200));
        end
      end
    end
    tests++; if (n == 0) begin fails++; $display("FAIL rdok_timeout: got 0 pops want 1"); end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    out_ready = 1'b1; aok_mode = 1; lat_min = 3; lat_max = 3;
    do_reset();
    repeat (2) cycle();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rmid_valid: got %b want 0", out_valid); end
    for (int i = 0; i < 20 && n == 0; i++) begin
      cycle();
      if (popped) begin
        n++;
        tests++;
        if (p_pc !== RESET_PC || p_inst !== word(RESET_PC)) begin
          fails++; $display("FAIL rmid_first: got pc=%h inst=%h want pc=%h inst=%h", p_pc, p_inst, RESET_PC, word(RESET_PC));
        end
      end
    end
    tests++; if (n == 0) begin fails++; $display("FAIL rmid_timeout: got 0 pops want 1"); end
  endtask

  // Reference: ID sees consecutive PCs from the latest redirect target, ending after a misaligned PC.
  task automatic test_random();
    logic [31:0] m_pc = RESET_PC;
    logic        m_halt = 1'b0;
    logic        redir, exp_adef;
    logic [31:0] tgt, exp_inst;
    int          n = 0;
    aok_mode = 2; lat_min = 0; lat_max = 3;
    do_reset();
    for (int i = 0; i < 800; i++) begin
      out_ready    = ($urandom_range(99) < 70);
      br_stall     = ($urandom_range(99) < 10);
      flush        = ($urandom_range(99) < 3);
      br_taken     = ($urandom_range(99) < 3);
      flush_target = {16'h1c00, 16'($urandom_range(16'hfffc)) & 16'hfffc};
      br_target    = {16'h1c01, 16'($urandom_range(16'hfffc)) & 16'hfffc};
      if ($urandom_range(99) < 15) flush_target[1:0] = 2'($urandom_range(3, 1));
      if ($urandom_range(99) < 15) br_target[1:0]    = 2'($urandom_range(3, 1));
      redir = flush || br_taken;
      tgt   = flush ? flush_target : br_target;
      cycle();
      if (popped) begin
        exp_adef = (m_pc[1:0] != 2'b00);
        exp_inst = exp_adef ? 32'h0 : word(m_pc);
        tests++;
        if (m_halt || p_pc !== m_pc || p_adef !== exp_adef || p_inst !== exp_inst) begin
          fails++;
          $display("FAIL rand_pop%0d: got pc=%h inst=%h adef=%b want pc=%h inst=%h adef=%b halted=%b",
                   n, p_pc, p_inst, p_adef, m_pc, exp_inst, exp_adef, m_halt);
        end
        if (exp_adef) m_halt = 1'b1;
        else m_pc += 32'd4;
        n++;
      end
      if (redir) begin
        m_pc = tgt; m_halt = 1'b0;
      end
    end
    flush = 1'b0; br_taken = 1'b0; br_stall = 1'b0;
    tests++; if (n < 100) begin fails++; $display("FAIL rand_progress: got %0d pops want >=100", n); end
    tests++; if (max_outst > MAX_OUTST) begin fails++; $display("FAIL rand_outst: got %0d want <=%0d", max_outst, MAX_OUTST); end
    tests++; if (blocked_req != 0) begin fails++; $display("FAIL blocked_req: got %0d requests during reset/redirect/stall want 0", blocked_req); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; flush = 1'b0; br_taken = 1'b0; br_stall = 1'b0;
    flush_target = '0; br_target = '0; out_ready = 1'b0;
    inst_sram_addr_ok = 1'b0; inst_sram_data_ok = 1'b0; inst_sram_rdata = '0;
    aok_mode = 1; lat_min = 1; lat_max = 1;
    acc_total = 0; req_cnt = 0; blocked_req = 0; max_outst = 0;
    @(negedge clk);
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_adef();
    test_br_stall();
    test_redirect_dataok();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
